// File: rtl/emtf_axi_pkg.sv
// Shared constants and types for the EMTF AXI RAM slave controller.
package emtf_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_DATA  = 3'd1,
    WR_RESP  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_DATA  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Burst address/beat tracker shared by the write and read channels.
module axi_burst_addr
  import emtf_axi_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] start_addr,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic [7:0]    beat,
  output logic          last_c
);

  logic [7:0] len_q;
  logic [1:0] burst_q;

  assign last_c = (beat == len_q);

  // FIXED holds the word; INCR, WRAP and the reserved code all step +1 mod depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      beat    <= '0;
      len_q   <= '0;
      burst_q <= FIXED;
    end else if (load) begin
      addr    <= start_addr;
      beat    <= '0;
      len_q   <= len;
      burst_q <= burst;
    end else if (step) begin
      beat <= beat + 8'd1;
      if (burst_q != FIXED) addr <= addr + AW'(1);
    end
  end

endmodule

// File: rtl/axi_ram_slave_ctrl.sv
// Single-outstanding AXI slave sequencing write/read bursts onto one
// single-port synchronous RAM; a waiting write beats a waiting read at IDLE.
module axi_ram_slave_ctrl
  import emtf_axi_pkg::*;
#(
  parameter int unsigned DW        = 64,
  parameter int unsigned AW        = 10,
  parameter int unsigned BASE_BITS = 32
) (
  input  logic                 s_aclk,
  input  logic                 s_aresetn,
  input  logic [5:0]           awid,
  input  logic [BASE_BITS-1:0] awaddr,
  input  logic [7:0]           awlen,
  input  logic [2:0]           awsize,
  input  logic [1:0]           awburst,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [DW-1:0]        wdata,
  input  logic [DW/8-1:0]      wstrb,
  input  logic                 wlast,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [5:0]           bid,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [5:0]           arid,
  input  logic [BASE_BITS-1:0] araddr,
  input  logic [7:0]           arlen,
  input  logic [2:0]           arsize,
  input  logic [1:0]           arburst,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [5:0]           rid,
  output logic [DW-1:0]        rdata,
  output logic [1:0]           rresp,
  output logic                 rlast,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 ram_en,
  output logic [DW/8-1:0]      ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_wdata,
  input  logic [DW-1:0]        ram_rdata
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned OFF = $clog2(NB);

  ctrl_state_e   state_q, state_d;
  logic [5:0]    id_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;
  logic          rd_held_q;

  logic          aw_hs, ar_hs, step;
  logic [AW-1:0] cur_addr, ld_addr;
  logic [7:0]    beat, ld_len;
  logic [1:0]    ld_burst;
  logic          last, ld_err;
  logic [DW-1:0] rd_fresh;
  logic          unused_ok;

  assign unused_ok = ^{awsize, arsize, awaddr[OFF-1:0], araddr[OFF-1:0], beat};

  assign aw_hs    = awvalid && awready;
  assign ar_hs    = arvalid && arready;
  assign ld_addr  = aw_hs ? awaddr[OFF+AW-1:OFF] : araddr[OFF+AW-1:OFF];
  assign ld_len   = aw_hs ? awlen : arlen;
  assign ld_burst = aw_hs ? awburst : arburst;
  assign ld_err   = aw_hs ? (awaddr[BASE_BITS-1:OFF+AW] != '0)
                          : (araddr[BASE_BITS-1:OFF+AW] != '0);
  assign rd_fresh = err_q ? '0 : ram_rdata;

  axi_burst_addr #(.AW(AW)) u_burst_addr (
    .clk        (s_aclk),
    .rst_n      (s_aresetn),
    .load       (aw_hs || ar_hs),
    .start_addr (ld_addr),
    .len        (ld_len),
    .burst      (ld_burst),
    .step       (step),
    .addr       (cur_addr),
    .beat       (beat),
    .last_c     (last)
  );

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Ready gating on s_aresetn keeps every output low while reset is held
  always_comb begin
    state_d   = state_q;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bid       = '0;
    bresp     = RESP_OKAY;
    rvalid    = 1'b0;
    rid       = '0;
    rresp     = RESP_OKAY;
    rlast     = 1'b0;
    rdata     = '0;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        awready = s_aresetn;
        arready = s_aresetn && !awvalid;
        if (awvalid && s_aresetn)      state_d = WR_DATA;
        else if (arvalid && s_aresetn) state_d = RD_ISSUE;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en    = 1'b1;
          ram_we    = err_q ? '0 : wstrb;
          ram_addr  = cur_addr;
          ram_wdata = wdata;
          step      = 1'b1;
          if (last) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready) state_d = IDLE;
      end
      RD_ISSUE: begin
        ram_en   = 1'b1;
        ram_addr = cur_addr;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        rid    = id_q;
        rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        rlast  = last;
        rdata  = rd_held_q ? rdata_q : rd_fresh;
        if (rready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            step    = 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM data is only guaranteed in the first RD_DATA cycle; hold it for stalls
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      id_q      <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rd_held_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        id_q  <= awid;
        err_q <= ld_err;
      end else if (ar_hs) begin
        id_q  <= arid;
        err_q <= ld_err;
      end else if (state_q == WR_DATA && wvalid) begin
        err_q <= err_q | (wlast != last);
      end
      if (state_q == RD_DATA && !rd_held_q) rdata_q <= rd_fresh;
      rd_held_q <= (state_q == RD_DATA) && (state_d == RD_DATA);
    end
  end

endmodule
